// File: rtl/dcfifo_pkg.sv
// -----------------------------------------------------------------------------
// dcfifo_pkg
// Shared definitions for the dual-clock FIFO pointer/occupancy stages.
//   ptr_width()  : pointer width for a given address width (one extra wrap bit)
//   bin2gray()   : binary to reflected Gray code
//   gray2bin()   : Gray code back to binary (prefix XOR from the MSB)
//   MODE_READ / MODE_WRITE : values accepted by the lpm_mode parameter
// Conversion functions work on 32-bit vectors; callers zero-extend their
// operand and truncate the result, so leading zeros have no effect.
// -----------------------------------------------------------------------------
package dcfifo_pkg;

    localparam string MODE_READ  = "READ";
    localparam string MODE_WRITE = "WRITE";

    function automatic int ptr_width(input int widthad);
        return widthad + 1;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Log-step prefix XOR: after the five passes every bit holds the XOR of
    // itself and all bits above it.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        b = b ^ (b >> 1);
        b = b ^ (b >> 2);
        b = b ^ (b >> 4);
        b = b ^ (b >> 8);
        b = b ^ (b >> 16);
        return b;
    endfunction

endpackage

// File: rtl/dcfifo_gray_sync.sv
// -----------------------------------------------------------------------------
// dcfifo_gray_sync
// Multi-flop synchroniser for a Gray-coded pointer arriving from the other
// clock domain. Only the last stage is presented on o_q.
//   clock      in   local domain clock
//   aclr       in   asynchronous active-high clear of every stage
//   i_d        in   [width-1:0] Gray pointer, asynchronous to clock
//   o_q        out  [width-1:0] synchronised Gray pointer
// -----------------------------------------------------------------------------
module dcfifo_gray_sync #(
    parameter int width      = 5,
    parameter int delay_sync = 3
) (
    input  logic             clock,
    input  logic             aclr,
    input  logic [width-1:0] i_d,
    output logic [width-1:0] o_q
);

    logic [width-1:0] r_stage [delay_sync];

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            for (int i = 0; i < delay_sync; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < delay_sync; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[delay_sync-1];

endmodule

// File: rtl/dcfifo_ptr_usedw.sv
// -----------------------------------------------------------------------------
// dcfifo_ptr_usedw
// Pointer and occupancy stage for one clock domain of the dual-clock FIFO.
// Holds the local pointer (write side in WRITE mode, read side in READ mode),
// exports it as a registered Gray pointer, synchronises the remote Gray
// pointer and produces a registered used-word count.
//   clock        in   domain clock
//   aclr         in   asynchronous active-high clear
//   i_req        in   local write/read request
//   i_blk        in   full (WRITE) / empty (READ) flag from the flag generator
//   i_rem_gray   in   [lpm_widthad:0] remote Gray pointer (asynchronous)
//   o_loc_gray   out  [lpm_widthad:0] local Gray pointer, registered
//   o_loc_ptr    out  [lpm_widthad:0] local binary pointer, registered
//   o_usedw      out  [lpm_widthad-1:0] used-word count, low bits
//   o_usedw_msb  out  set only when exactly lpm_numwords words are held
//   o_inc        out  combinational: pointer advances at this edge
// -----------------------------------------------------------------------------
module dcfifo_ptr_usedw
    import dcfifo_pkg::*;
#(
    parameter int    lpm_widthad        = 4,
    parameter int    lpm_numwords       = 16,
    parameter string lpm_mode           = "WRITE",
    parameter int    delay_sync         = 3,
    parameter string underflow_checking = "ON",
    parameter string overflow_checking  = "ON"
) (
    input  logic                   clock,
    input  logic                   aclr,
    input  logic                   i_req,
    input  logic                   i_blk,
    input  logic [lpm_widthad:0]   i_rem_gray,
    output logic [lpm_widthad:0]   o_loc_gray,
    output logic [lpm_widthad:0]   o_loc_ptr,
    output logic [lpm_widthad-1:0] o_usedw,
    output logic                   o_usedw_msb,
    output logic                   o_inc
);

    localparam int PTR_W    = ptr_width(lpm_widthad);
    localparam bit IS_WRITE = (lpm_mode == MODE_WRITE);
    localparam bit CHECK_ON = IS_WRITE ? (overflow_checking == "ON")
                                       : (underflow_checking == "ON");

    if (lpm_numwords != (1 << lpm_widthad)) begin : g_bad_depth
        $error("dcfifo_ptr_usedw: lpm_numwords must equal 2**lpm_widthad");
    end
    if (delay_sync < 2 || delay_sync > 4) begin : g_bad_sync
        $error("dcfifo_ptr_usedw: delay_sync must be in 2..4");
    end
    if (lpm_mode != MODE_WRITE && lpm_mode != MODE_READ) begin : g_bad_mode
        $error("dcfifo_ptr_usedw: lpm_mode must be READ or WRITE");
    end

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] r_gray;
    logic [PTR_W-1:0] r_occ;
    logic [PTR_W-1:0] w_ptr_nxt;
    logic [PTR_W-1:0] w_rem_gray_sync;
    logic [PTR_W-1:0] w_rem_bin;
    logic [PTR_W-1:0] w_diff;
    logic             w_inc;

    assign w_inc     = i_req & ~(CHECK_ON & i_blk);
    assign w_ptr_nxt = r_ptr + PTR_W'(1);

    dcfifo_gray_sync #(
        .width      (PTR_W),
        .delay_sync (delay_sync)
    ) u_rem_sync (
        .clock (clock),
        .aclr  (aclr),
        .i_d   (i_rem_gray),
        .o_q   (w_rem_gray_sync)
    );

    assign w_rem_bin = PTR_W'(gray2bin(32'(w_rem_gray_sync)));

    // Modular subtraction on the extra-bit pointers gives the exact occupancy
    // 0..lpm_numwords, including across the pointer wrap.
    if (IS_WRITE) begin : g_diff_write
        assign w_diff = r_ptr - w_rem_bin;
    end else begin : g_diff_read
        assign w_diff = w_rem_bin - r_ptr;
    end

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            r_ptr  <= '0;
            r_gray <= '0;
            r_occ  <= '0;
        end else begin
            if (w_inc) begin
                r_ptr  <= w_ptr_nxt;
                r_gray <= PTR_W'(bin2gray(32'(w_ptr_nxt)));
            end
            r_occ <= w_diff;
        end
    end

    assign o_loc_ptr   = r_ptr;
    assign o_loc_gray  = r_gray;
    assign o_usedw     = r_occ[PTR_W-2:0];
    assign o_usedw_msb = r_occ[PTR_W-1];
    assign o_inc       = w_inc;

endmodule
